// File: rtl/counter_seq_ctrl.sv
// counter_seq_ctrl: start/halt/pause sequencer for a prescaled up-counter with one-shot or auto-reload
module counter_seq_ctrl #(
  parameter int WIDTH  = 4,
  parameter int PSC_W  = 4,
  parameter int WRAP_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              halt,
  input  logic              pause,
  input  logic              auto_reload,
  input  logic [WIDTH-1:0]  limit,
  input  logic [PSC_W-1:0]  psc,
  output logic [WIDTH-1:0]  cnt,
  output logic              busy,
  output logic              done,
  output logic [WRAP_W-1:0] wraps
);
  typedef enum logic [1:0] {IDLE, RUN, PAUSE, DONE} state_t;
  state_t state_q, state_d;
  logic [WIDTH-1:0] cnt_q, cnt_d, limit_q, limit_d;
  logic [PSC_W-1:0] pre_q, pre_d, psc_q, psc_d;
  logic [WRAP_W-1:0] wraps_q, wraps_d;
  logic done_q, done_d, auto_q, auto_d;
  logic adv, term;
  assign adv   = pre_q == psc_q;
  assign term  = cnt_q == limit_q;
  assign cnt   = cnt_q;
  assign busy  = (state_q == RUN) || (state_q == PAUSE);
  assign done  = done_q;
  assign wraps = wraps_q;
  // next state: halt beats everything, then pause, then the prescaled advance
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    pre_d   = pre_q;
    wraps_d = wraps_q;
    limit_d = limit_q;
    psc_d   = psc_q;
    auto_d  = auto_q;
    done_d  = 1'b0;
    if (halt) begin
      state_d = IDLE;
      cnt_d   = '0;
      pre_d   = '0;
    end else begin
      case (state_q)
        IDLE, DONE: if (start) begin
          state_d = RUN;
          limit_d = limit;
          psc_d   = psc;
          auto_d  = auto_reload;
          cnt_d   = '0;
          pre_d   = '0;
          wraps_d = '0;
        end
        RUN: if (pause) state_d = PAUSE;
          else if (!adv) pre_d = pre_q + 1'b1;
          else begin
            pre_d = '0;
            if (!term) cnt_d = cnt_q + 1'b1;
            else begin
              done_d = 1'b1;
              if (auto_q) begin
                cnt_d   = '0;
                wraps_d = &wraps_q ? wraps_q : wraps_q + 1'b1;
              end else state_d = DONE;
            end
          end
        PAUSE: if (!pause) state_d = RUN;
        default: state_d = IDLE;
      endcase
    end
  end
  // state and datapath registers, asynchronously cleared
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      pre_q   <= '0;
      wraps_q <= '0;
      limit_q <= '0;
      psc_q   <= '0;
      auto_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      pre_q   <= pre_d;
      wraps_q <= wraps_d;
      limit_q <= limit_d;
      psc_q   <= psc_d;
      auto_q  <= auto_d;
      done_q  <= done_d;
    end
  end
endmodule
